// File: rtl/dac_spi_pkg.sv
// Shared encodings and helpers for the DAC SPI write master.
package dac_spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StShift = 3'd2;
  localparam state_t StHold  = 3'd3;
  localparam state_t StGap   = 3'd4;
  localparam state_t StLdac  = 3'd5;

  // SPI mode 3: SCK idles high, data launched on falling edge, sampled on rising edge.
  localparam logic SpiCpol = 1'b1;
  localparam logic SpiCpha = 1'b1;
  // SCK level held just before a launch edge
  localparam logic SckLaunchLvl = SpiCpol ~^ SpiCpha;

  function automatic int unsigned frame_w(input int unsigned prefix_w, input int unsigned data_w);
    return prefix_w + data_w;
  endfunction

endpackage

// File: rtl/dac_spi_tick_gen.sv
// SCK half-period divider: counts 0..CLK_DIV-1 and ticks on the last count.
module dac_spi_tick_gen #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick,
  output logic o_tick_next
);

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] r_cnt;
  logic [DivW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt + DivW'(1);
    if (i_clear || (r_cnt == DivMax)) begin
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_tick      = (r_cnt == DivMax);
  assign o_tick_next = (w_cnt_d == DivMax);

endmodule

// File: rtl/dac_spi_master.sv
// SPI (mode 3) write master for serial DACs: {prefix, data} frames, MSB first, CS framed.
// Optional LDAC strobe after each frame when DAC_SPI_LDAC_EN is defined.
module dac_spi_master
  import dac_spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned PREFIX_W = 4,
  parameter int unsigned CLK_DIV  = 6,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic                clk12MHz,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PREFIX_W-1:0] in_prefix,
  input  logic [DATA_W-1:0]   in_data,
  output logic                sdo,
  output logic                cs,
  output logic                sck,
  output logic                busy,
  output logic                done
`ifdef DAC_SPI_LDAC_EN
  ,
  output logic                ldac_n
`endif
);

  localparam int unsigned FrameW = frame_w(PREFIX_W, DATA_W);
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned GapW   = $clog2(CS_GAP) + 1;
  localparam logic [BitW-1:0] BitMax  = BitW'(FrameW - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);
`ifdef DAC_SPI_LDAC_EN
  localparam state_t          WaitSt  = StLdac;
  localparam logic [GapW-1:0] WaitCnt = GapW'(1);
`else
  localparam state_t          WaitSt  = StGap;
  localparam logic [GapW-1:0] WaitCnt = GapLast;
`endif

  state_t            r_state, w_state_d;
  logic [FrameW-1:0] r_shift, w_shift_d;
  logic [BitW-1:0]   r_bit_cnt, w_bit_cnt_d;
  logic [GapW-1:0]   r_gap_cnt, w_gap_cnt_d;
  logic              r_cs, w_cs_d;
  logic              r_sck, w_sck_d;
  logic              r_sdo, w_sdo_d;
  logic              r_ready, w_ready_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
`ifdef DAC_SPI_LDAC_EN
  logic              r_ldac_n, w_ldac_n_d;
`endif

  logic w_tick;
  logic w_tick_next;
  logic w_accept;

  assign w_accept = in_valid && r_ready;

  dac_spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk       (clk12MHz),
    .i_rst       (rst),
    .i_clear     (r_state == StIdle),
    .o_tick      (w_tick),
    .o_tick_next (w_tick_next)
  );

  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_cs      <= 1'b1;
      r_sck     <= SpiCpol;
      r_sdo     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
      r_ldac_n  <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_gap_cnt <= w_gap_cnt_d;
      r_cs      <= w_cs_d;
      r_sck     <= w_sck_d;
      r_sdo     <= w_sdo_d;
      r_ready   <= w_ready_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
`ifdef DAC_SPI_LDAC_EN
      r_ldac_n  <= w_ldac_n_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StSetup;
      StSetup: if (w_tick) w_state_d = StShift;
      StShift: begin
        if (w_tick && (r_sck != SckLaunchLvl) && (r_bit_cnt == '0)) w_state_d = StHold;
      end
      StHold:  if (w_tick) w_state_d = StGap;
      StGap: begin
        if (w_tick && (r_gap_cnt == GapLast)) begin
`ifdef DAC_SPI_LDAC_EN
          w_state_d = StLdac;
`else
          w_state_d = w_accept ? StSetup : StIdle;
`endif
        end
      end
`ifdef DAC_SPI_LDAC_EN
      StLdac: begin
        if (w_tick && (r_gap_cnt == GapW'(1))) w_state_d = w_accept ? StSetup : StIdle;
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_gap_cnt_d = r_gap_cnt;
    w_cs_d      = r_cs;
    w_sck_d     = r_sck;
    w_sdo_d     = r_sdo;
    w_ready_d   = r_ready;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
`ifdef DAC_SPI_LDAC_EN
    w_ldac_n_d  = r_ldac_n;
`endif
    unique case (r_state)
      StShift: begin
        if (w_tick) begin
          w_sck_d = ~r_sck;
          if (r_sck == SckLaunchLvl) begin
            w_sdo_d   = r_shift[FrameW-1];
            w_shift_d = {r_shift[FrameW-2:0], 1'b0};
          end else if (r_bit_cnt != '0) begin
            w_bit_cnt_d = r_bit_cnt - BitW'(1);
          end
        end
      end
      StHold: begin
        if (w_tick) begin
          w_cs_d      = 1'b1;
          w_done_d    = 1'b1;
          w_sdo_d     = 1'b0;
          w_gap_cnt_d = '0;
        end
      end
      StGap: begin
        if (w_tick) begin
          w_gap_cnt_d = r_gap_cnt + GapW'(1);
`ifdef DAC_SPI_LDAC_EN
          if (r_gap_cnt == GapLast) begin
            w_gap_cnt_d = '0;
            w_ldac_n_d  = 1'b0;
          end
`endif
        end
      end
`ifdef DAC_SPI_LDAC_EN
      StLdac: begin
        if (w_tick) begin
          w_gap_cnt_d = r_gap_cnt + GapW'(1);
          if (r_gap_cnt == GapW'(1)) w_ldac_n_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // Ready rises during the last wait cycle so a held in_valid is taken on the frame-ending edge.
    if ((w_state_d == StIdle) ||
        ((w_state_d == WaitSt) && (w_gap_cnt_d == WaitCnt) && w_tick_next)) begin
      w_ready_d = 1'b1;
    end
    if (w_state_d == StIdle) w_busy_d = 1'b0;

    if (w_accept) begin
      w_shift_d   = {in_prefix, in_data};
      w_bit_cnt_d = BitMax;
      w_ready_d   = 1'b0;
      w_busy_d    = 1'b1;
      w_cs_d      = 1'b0;
      w_sck_d     = SpiCpol;
    end
  end

  assign in_ready = r_ready;
  assign sdo      = r_sdo;
  assign cs       = r_cs;
  assign sck      = r_sck;
  assign busy     = r_busy;
  assign done     = r_done;
`ifdef DAC_SPI_LDAC_EN
  assign ldac_n   = r_ldac_n;
`endif

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master: 16-bit frame at CLK_DIV=2 and a 24-bit frame at CLK_DIV=1.
module tb_dac_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_prefix = '0;
  logic [11:0] in_data = '0;
  logic        in_ready, sdo, cs, sck, busy, done;

  logic        wd_valid = 1'b0;
  logic [7:0]  wd_prefix = '0;
  logic [15:0] wd_data = '0;
  logic        wd_ready, wd_sdo, wd_cs, wd_sck, wd_busy, wd_done;
`ifdef DAC_SPI_LDAC_EN
  logic        ldac_n, wd_ldac_n;
`endif

  dac_spi_master #(.DATA_W(12), .PREFIX_W(4), .CLK_DIV(2), .CS_GAP(2)) u_dut (
    .clk12MHz (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prefix(in_prefix),
    .in_data  (in_data),
    .sdo      (sdo),
    .cs       (cs),
    .sck      (sck),
    .busy     (busy),
    .done     (done)
`ifdef DAC_SPI_LDAC_EN
    ,
    .ldac_n   (ldac_n)
`endif
  );

  dac_spi_master #(.DATA_W(16), .PREFIX_W(8), .CLK_DIV(1), .CS_GAP(2)) u_wide (
    .clk12MHz (clk),
    .rst      (rst),
    .in_valid (wd_valid),
    .in_ready (wd_ready),
    .in_prefix(wd_prefix),
    .in_data  (wd_data),
    .sdo      (wd_sdo),
    .cs       (wd_cs),
    .sck      (wd_sck),
    .busy     (wd_busy),
    .done     (wd_done)
`ifdef DAC_SPI_LDAC_EN
    ,
    .ldac_n   (wd_ldac_n)
`endif
  );

  int total = 0;
  int bad = 0;

  // Bus monitors, sampled on the falling clock edge.
  int unsigned cyc = 0;
  int unsigned n_rise = 0, n_cslow = 0, n_done = 0;
  logic [31:0] cap = '0;
  logic        prev_sck = 1'b1;
  int unsigned wd_rise = 0, wd_cslow = 0, wd_ndone = 0, wd_period_bad = 0, wd_last = 0;
  logic [31:0] wd_cap = '0;
  logic        wd_prev_sck = 1'b1, wd_have_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!prev_sck && sck && !cs) begin
      n_rise++;
      cap = {cap[30:0], sdo};
    end
    if (!cs) n_cslow++;
    if (done) n_done++;
    prev_sck = sck;

    if (wd_cs) wd_have_last = 1'b0;
    if (!wd_prev_sck && wd_sck && !wd_cs) begin
      wd_rise++;
      wd_cap = {wd_cap[30:0], wd_sdo};
      if (wd_have_last && (cyc - wd_last != 2)) wd_period_bad++;
      wd_last = cyc;
      wd_have_last = 1'b1;
    end
    if (!wd_cs) wd_cslow++;
    if (wd_done) wd_ndone++;
    wd_prev_sck = wd_sck;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cs !== 1'b1)       begin bad++; $display("FAIL reset_cs: got %b want 1", cs); end
    total++; if (sck !== 1'b1)      begin bad++; $display("FAIL reset_sck: got %b want 1", sck); end
    total++; if (sdo !== 1'b0)      begin bad++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int unsigned r0, c0, d0;
    int k;
    @(posedge clk); #1;
    r0 = n_rise; c0 = n_cslow; d0 = n_done;
    @(negedge clk);
    in_prefix = 4'b0011; in_data = 12'hA5C; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); k = 1;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1 || cs !== 1'b0) begin
      bad++; $display("FAIL frame_start: ready=%b busy=%b cs=%b want 0 1 0", in_ready, busy, cs);
    end
    while (in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total++; if (k != 72) begin bad++; $display("FAIL frame_ready_latency: got %0d want 72", k); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_idle: got %b want 0", busy); end
    @(posedge clk); #1;
    total++; if (n_rise - r0 != 16) begin bad++; $display("FAIL frame_rises: got %0d want 16", n_rise - r0); end
    total++; if (n_cslow - c0 != 68) begin bad++; $display("FAIL frame_cs_low: got %0d want 68", n_cslow - c0); end
    total++; if (n_done - d0 != 1) begin bad++; $display("FAIL frame_done: got %0d want 1", n_done - d0); end
    total++; if (cap[15:0] !== 16'h3A5C) begin bad++; $display("FAIL frame_bits: got %h want 3a5c", cap[15:0]); end
  endtask

  task automatic test_back_to_back();
    int unsigned r0;
    int k, gap;
    @(negedge clk);
    in_prefix = 4'b0011; in_data = 12'h000; in_valid = 1'b1;
    @(posedge clk); #1 in_data = 12'hFFF;
    k = 0;
    @(negedge clk);
    while (cs !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    gap = 0;
    while (cs === 1'b1 && gap < 20) begin gap++; @(negedge clk); end
    in_valid = 1'b0;
    total++; if (gap != 4) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 4", gap); end
    @(posedge clk); #1;
    total++; if (cap[15:0] !== 16'h3000) begin bad++; $display("FAIL b2b_first_bits: got %h want 3000", cap[15:0]); end
    r0 = n_rise;
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    total++; if (n_rise - r0 != 16) begin bad++; $display("FAIL b2b_second_rises: got %0d want 16", n_rise - r0); end
    total++; if (cap[15:0] !== 16'h3FFF) begin bad++; $display("FAIL b2b_second_bits: got %h want 3fff", cap[15:0]); end
  endtask

  task automatic test_input_hold();
    int k, ready_seen;
    @(negedge clk);
    in_prefix = 4'b1011; in_data = 12'h5A5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    in_data = 12'h123; in_prefix = 4'h0;
    k = 20; ready_seen = 0;
    while (k < 71) begin
      if (in_ready !== 1'b0) ready_seen++;
      @(negedge clk); k++;
    end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL hold_ready_low: got %0d high cycles want 0", ready_seen); end
    while (in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    total++; if (cap[15:0] !== 16'hB5A5) begin bad++; $display("FAIL hold_bits: got %h want b5a5", cap[15:0]); end
  endtask

  task automatic test_reset_mid();
    int unsigned r0, c0, d0;
    int k;
    @(posedge clk); #1;
    r0 = n_rise; d0 = n_done;
    @(negedge clk);
    in_prefix = 4'b0011; in_data = 12'hFFF; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    while (n_rise - r0 < 7 && k < 200) begin @(posedge clk); #1; k++; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if (cs !== 1'b1 || sck !== 1'b1 || sdo !== 1'b0) begin
      bad++; $display("FAIL rstmid_pins: cs=%b sck=%b sdo=%b want 1 1 0", cs, sck, sdo);
    end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_hs: ready=%b busy=%b want 1 0", in_ready, busy);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    total++; if (n_done - d0 != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", n_done - d0); end
    r0 = n_rise; c0 = n_cslow;
    @(negedge clk);
    in_data = 12'h3C3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    total++; if (n_rise - r0 != 16 || n_cslow - c0 != 68) begin
      bad++; $display("FAIL rstmid_next_frame: rises=%0d cslow=%0d want 16 68", n_rise - r0, n_cslow - c0);
    end
    total++; if (cap[15:0] !== 16'h33C3) begin bad++; $display("FAIL rstmid_next_bits: got %h want 33c3", cap[15:0]); end
  endtask

  task automatic test_wide();
    int unsigned r0, c0, d0, p0;
    int k;
    @(posedge clk); #1;
    r0 = wd_rise; c0 = wd_cslow; d0 = wd_ndone; p0 = wd_period_bad;
    @(negedge clk);
    wd_prefix = 8'h3C; wd_data = 16'hBEEF; wd_valid = 1'b1;
    @(posedge clk); #1 wd_valid = 1'b0;
    @(negedge clk); k = 1;
    while (wd_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total++; if (k != 52) begin bad++; $display("FAIL wide_ready_latency: got %0d want 52", k); end
    @(posedge clk); #1;
    total++; if (wd_rise - r0 != 24) begin bad++; $display("FAIL wide_rises: got %0d want 24", wd_rise - r0); end
    total++; if (wd_cslow - c0 != 50) begin bad++; $display("FAIL wide_cs_low: got %0d want 50", wd_cslow - c0); end
    total++; if (wd_ndone - d0 != 1) begin bad++; $display("FAIL wide_done: got %0d want 1", wd_ndone - d0); end
    total++; if (wd_period_bad - p0 != 0) begin
      bad++; $display("FAIL wide_sck_period: got %0d off-period edges want 0", wd_period_bad - p0);
    end
    total++; if (wd_cap[23:0] !== 24'h3CBEEF) begin
      bad++; $display("FAIL wide_bits: got %h want 3cbeef", wd_cap[23:0]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_input_hold();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
